// File: rtl/i2c_byte_engine.sv
// Bit/byte-level I2C master PHY: executes START / WRITE / READ / STOP primitives on open-drain pads.
// Define I2C_CLOCK_STRETCH_EN to let slaves stretch SCL during the release quarter.
module i2c_byte_engine #(
    parameter int unsigned DIV_QUARTER = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       bus_held,
    input  logic       scl_in,
    output logic       scl_t,
    output logic       scl_out,
    input  logic       sda_in,
    output logic       sda_t,
    output logic       sda_out
);
    localparam logic [2:0]  OpStart     = 3'b001;
    localparam logic [2:0]  OpWrite     = 3'b010;
    localparam logic [2:0]  OpRead      = 3'b011;
    localparam logic [2:0]  OpStop      = 3'b100;
    localparam logic [15:0] QuarterLast = 16'(DIV_QUARTER - 1);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  shift_q, shift_d;
    logic        nack_q, nack_d;
    logic        ack_q, ack_d;
    logic        scl_t_q, scl_t_d;
    logic        sda_t_q, sda_t_d;
    logic        held_q, held_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_nack_q, rsp_nack_d;
    logic        rsp_err_q, rsp_err_d;
    logic        active, stretch, legal, cmd_bad, enter;

    assign active  = (state_q != StIdle) && (state_q != StDone);
    assign legal   = (cmd_op == OpStart) || (cmd_op == OpWrite) ||
                     (cmd_op == OpRead)  || (cmd_op == OpStop);
    assign cmd_bad = !legal || ((cmd_op != OpStart) && !held_q);

`ifdef I2C_CLOCK_STRETCH_EN
    // Every active state releases SCL in Q1; the quarter starts once SCL is really high.
    assign stretch = active && (quarter_q == 2'd1) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stretch       = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            quarter_q  <= 2'd0;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            op_q       <= 3'd0;
            shift_q    <= 8'd0;
            nack_q     <= 1'b0;
            ack_q      <= 1'b1;
            scl_t_q    <= 1'b1;
            sda_t_q    <= 1'b1;
            held_q     <= 1'b0;
            rsp_data_q <= 8'd0;
            rsp_nack_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            quarter_q  <= quarter_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            op_q       <= op_d;
            shift_q    <= shift_d;
            nack_q     <= nack_d;
            ack_q      <= ack_d;
            scl_t_q    <= scl_t_d;
            sda_t_q    <= sda_t_d;
            held_q     <= held_d;
            rsp_data_q <= rsp_data_d;
            rsp_nack_q <= rsp_nack_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        quarter_d  = quarter_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        op_d       = op_q;
        shift_d    = shift_q;
        nack_d     = nack_q;
        ack_d      = ack_q;
        scl_t_d    = scl_t_q;
        sda_t_d    = sda_t_q;
        held_d     = held_q;
        rsp_data_d = rsp_data_q;
        rsp_nack_d = rsp_nack_q;
        rsp_err_d  = rsp_err_q;
        enter      = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    shift_d   = cmd_data;
                    nack_d    = cmd_nack;
                    cnt_d     = 16'd0;
                    quarter_d = 2'd0;
                    bit_d     = 3'd0;
                    if (cmd_bad) begin
                        state_d    = StDone;
                        rsp_err_d  = 1'b1;
                        rsp_nack_d = 1'b0;
                    end else begin
                        enter = 1'b1;
                        case (cmd_op)
                            OpStart:        state_d = StStart;
                            OpWrite, OpRead: state_d = StBit;
                            default:        state_d = StStop;
                        endcase
                    end
                end
            end
            StStart, StBit, StAck, StStop: begin
                if (stretch) begin
                    cnt_d = 16'd0;
                end else if (cnt_q != QuarterLast) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d     = 16'd0;
                    quarter_d = quarter_q + 2'd1;
                    enter     = 1'b1;
                    if (quarter_q == 2'd2) begin
                        if (state_q == StBit) shift_d = {shift_q[6:0], sda_in};
                        if (state_q == StAck) ack_d = sda_in;
                    end
                    if (quarter_q == 2'd3) begin
                        if (state_q == StBit) begin
                            if (bit_q == 3'd7) state_d = StAck;
                            else               bit_d   = bit_q + 3'd1;
                        end else begin
                            state_d    = StDone;
                            enter      = 1'b0;
                            rsp_err_d  = 1'b0;
                            rsp_nack_d = (op_q == OpWrite) && ack_q;
                            if (op_q == OpRead)  rsp_data_d = shift_q;
                            if (state_q == StStart) held_d = 1'b1;
                            if (state_q == StStop)  held_d = 1'b0;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Line actions are applied on entry to each quarter so they hold for its whole length.
        if (enter) begin
            case (state_d)
                StStart: begin
                    case (quarter_d)
                        2'd0:    sda_t_d = 1'b1;
                        2'd1:    scl_t_d = 1'b1;
                        2'd2:    sda_t_d = 1'b0;
                        default: scl_t_d = 1'b0;
                    endcase
                end
                StBit, StAck: begin
                    case (quarter_d)
                        2'd0: begin
                            scl_t_d = 1'b0;
                            if (state_d == StBit) sda_t_d = (op_d == OpWrite) ? shift_d[7] : 1'b1;
                            else                  sda_t_d = (op_d == OpWrite) ? 1'b1 : nack_d;
                        end
                        2'd1:    scl_t_d = 1'b1;
                        2'd3:    scl_t_d = 1'b0;
                        default: ;
                    endcase
                end
                StStop: begin
                    case (quarter_d)
                        2'd0:    sda_t_d = 1'b0;
                        2'd1:    scl_t_d = 1'b1;
                        2'd2:    sda_t_d = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign rsp_err   = rsp_err_q;
    assign bus_held  = held_q;
    assign scl_t     = scl_t_q;
    assign sda_t     = sda_t_q;
    assign scl_out   = 1'b0;
    assign sda_out   = 1'b0;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// Scoreboard bench for i2c_byte_engine with a small open-drain slave model.
// Define I2C_CLOCK_STRETCH_EN to include the clock-stretch scenario.
module tb_i2c_byte_engine;
    localparam int unsigned Div = 4;
    localparam logic [2:0] OpStart = 3'b001;
    localparam logic [2:0] OpWrite = 3'b010;
    localparam logic [2:0] OpRead  = 3'b011;
    localparam logic [2:0] OpStop  = 3'b100;

    typedef struct packed {
        logic [7:0] data;
        logic       nack;
        logic       err;
    } rsp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_held;
    logic [7:0] rsp_data;
    logic       scl_in, scl_t, scl_out, sda_in, sda_t, sda_out;

    // Slave model: mode 0 passive, 1 transmits slv_byte, 2 ACKs a master write.
    int         slv_mode = 0;
    logic [7:0] slv_byte = 8'd0;
    logic       slv_clear = 1'b0;
    logic       slv_sda;
    logic       stretch_hold = 1'b0;
    int         falls = 0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       rise_q[$];
    int         low_cnt = 0;
    int         rsp_cnt = 0;
    int         stop_edges = 0;

    rsp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       model_held = 1'b0;
    logic [7:0] model_data = 8'd0;
    int         exp_cyc = 0;

    assign scl_in = scl_t & ~stretch_hold;
    assign sda_in = sda_t & slv_sda;

    i2c_byte_engine #(.DIV_QUARTER(Div)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .rsp_err(rsp_err), .bus_held(bus_held),
        .scl_in(scl_in), .scl_t(scl_t), .scl_out(scl_out),
        .sda_in(sda_in), .sda_t(sda_t), .sda_out(sda_out)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        slv_sda = 1'b1;
        if (slv_mode == 1 && falls < 8)       slv_sda = slv_byte[3'(7 - falls)];
        else if (slv_mode == 2 && falls == 8) slv_sda = 1'b0;
    end

    always @(negedge CLK) begin
        if (slv_clear)                falls <= 0;
        else if (scl_prev && !scl_in) falls <= falls + 1;
        if (!scl_prev && scl_in) rise_q.push_back(sda_in);
        if (!sda_prev && sda_in && scl_in && scl_prev) stop_edges <= stop_edges + 1;
        if (!scl_t || !sda_t) low_cnt <= low_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        scl_prev <= scl_in;
        sda_prev <= sda_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic nack,
                         input int mode, input logic [7:0] sbyte);
        rsp_t e;
        logic bad;
        int   t;
        @(posedge CLK); #1;
        slv_clear = 1'b1;
        slv_mode  = mode;
        slv_byte  = sbyte;
        cmd_op    = op;
        cmd_data  = data;
        cmd_nack  = nack;
        cmd_valid = 1'b1;
        bad = !(op inside {OpStart, OpWrite, OpRead, OpStop}) || (op != OpStart && !model_held);
        e.err  = bad;
        e.nack = (op == OpWrite && !bad) ? (mode != 2) : 1'b0;
        e.data = (op == OpRead && !bad) ? sbyte : model_data;
        model_data = e.data;
        if (!bad && op == OpStart) model_held = 1'b1;
        if (!bad && op == OpStop)  model_held = 1'b0;
        exp_cyc = bad ? 0 : (op == OpStart || op == OpStop) ? 4 * Div : 36 * Div;
        exp_q.push_back(e);
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge CLK); #1;
            t++;
        end
        if (!cmd_ready) check_eq("accept_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        slv_clear = 1'b0;
    endtask

    task automatic wait_rsp();
        rsp_t e;
        int   cyc;
        cyc = 0;
        @(negedge CLK);
        while (!rsp_valid && cyc < 2000) begin
            cyc++;
            @(negedge CLK);
        end
        check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check_eq("cycles", cyc, exp_cyc);
        check_eq("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            check_eq("rsp_nack", {31'd0, rsp_nack}, {31'd0, e.nack});
            check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        check_eq("bus_held", {31'd0, bus_held}, {31'd0, model_held});
        @(negedge CLK);
        check_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check_eq("ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_bits(input int base, input logic [7:0] b, input logic ackbit);
        check_eq("rise_count", rise_q.size() - base, 9);
        if (rise_q.size() >= base + 9) begin
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("sda_bit%0d", 7 - i), {31'd0, rise_q[base + i]}, {31'd0, b[7 - i]});
            check_eq("ack_bit", {31'd0, rise_q[base + 8]}, {31'd0, ackbit});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, snap_low, snap_rsp, snap_stop;
        repeat (3) @(negedge CLK);
        check_eq("rst_scl_t", {31'd0, scl_t}, 32'd1);
        check_eq("rst_sda_t", {31'd0, sda_t}, 32'd1);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        check_eq("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_bus_held", {31'd0, bus_held}, 32'd0);
        check_eq("scl_out", {31'd0, scl_out}, 32'd0);
        check_eq("sda_out", {31'd0, sda_out}, 32'd0);
        RST = 1'b0;

        issue(OpStart, 8'h00, 1'b0, 0, 8'h00);
        wait_rsp();
        check_eq("start_scl_low", {31'd0, scl_t}, 32'd0);
        check_eq("start_sda_low", {31'd0, sda_t}, 32'd0);

        base = rise_q.size();
        issue(OpWrite, 8'h7C, 1'b0, 2, 8'h00);
        wait_rsp();
        check_bits(base, 8'h7C, 1'b0);

        base = rise_q.size();
        issue(OpWrite, 8'hA5, 1'b0, 0, 8'h00);
        wait_rsp();
        check_bits(base, 8'hA5, 1'b1);
        check_eq("scl_low_after", {31'd0, scl_t}, 32'd0);

        base = rise_q.size();
        issue(OpRead, 8'h00, 1'b0, 1, 8'h5A);
        wait_rsp();
        check_bits(base, 8'h5A, 1'b0);

        base = rise_q.size();
        issue(OpRead, 8'h00, 1'b1, 1, 8'h3C);
        wait_rsp();
        check_bits(base, 8'h3C, 1'b1);

        snap_stop = stop_edges;
        issue(OpStop, 8'h00, 1'b0, 0, 8'h00);
        wait_rsp();
        check_eq("stop_condition", stop_edges - snap_stop, 1);
        check_eq("stop_scl_t", {31'd0, scl_t}, 32'd1);
        check_eq("stop_sda_t", {31'd0, sda_t}, 32'd1);

        snap_low = low_cnt;
        issue(OpWrite, 8'hFF, 1'b0, 0, 8'h00);
        wait_rsp();
        issue(3'b111, 8'h00, 1'b0, 0, 8'h00);
        wait_rsp();
        check_eq("err_no_line_activity", low_cnt - snap_low, 0);

        // Reset in quarter 17 of a WRITE (bit 4, Q1): SDA carries a 0 data bit.
        issue(OpStart, 8'h00, 1'b0, 0, 8'h00);
        wait_rsp();
        issue(OpWrite, 8'h55, 1'b0, 2, 8'h00);
        repeat (17 * Div) @(posedge CLK);
        @(negedge CLK);
        check_eq("pre_rst_sda_t", {31'd0, sda_t}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        check_eq("mid_rst_scl_t", {31'd0, scl_t}, 32'd1);
        check_eq("mid_rst_sda_t", {31'd0, sda_t}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mid_rst_held", {31'd0, bus_held}, 32'd0);
        check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        RST = 1'b0;
        exp_q.delete();
        model_held = 1'b0;
        snap_rsp = rsp_cnt;
        repeat (40 * Div) @(negedge CLK);
        check_eq("no_rsp_after_rst", rsp_cnt - snap_rsp, 0);

`ifdef I2C_CLOCK_STRETCH_EN
        issue(OpStart, 8'h00, 1'b0, 0, 8'h00);
        wait_rsp();
        base = rise_q.size();
        issue(OpWrite, 8'h96, 1'b0, 2, 8'h00);
        exp_cyc = exp_cyc + 20;
        fork
            wait_rsp();
            begin : stretcher
                int t, hold;
                t = 0;
                hold = 0;
                while (falls != 3 && t < 1000) begin
                    @(negedge CLK);
                    t++;
                end
                stretch_hold = 1'b1;
                while (hold < 20 && t < 2000) begin
                    @(negedge CLK);
                    t++;
                    if (scl_t) hold++;
                end
                stretch_hold = 1'b0;
            end
        join
        check_bits(base, 8'h96, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_byte_engine.md
Name: i2c_byte_engine

Overview:
Bit/byte-level I2C master PHY directly below the FMC424 I2C controller. Accepts one bus primitive per command (START / WRITE byte / READ byte / STOP) and generates open-drain SCL/SDA timing. Returns one response per command, carrying ACK status or read data. Drives the FPGA IOBUF T/O pins; the controller FSM contains only sequencing.

Parameters:
DIV_QUARTER, 250, CLK cycles per quarter SCL period (100 kHz at 100 MHz CLK); legal range 2..65535

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  engine accepts command this cycle
cmd_op  in  3  3'b001 START, 3'b010 WRITE, 3'b011 READ, 3'b100 STOP; others illegal
cmd_data  in  8  WRITE byte, MSB first
cmd_nack  in  1  READ only: 1 = master sends NACK after byte (last read)
rsp_valid  out  1  one-cycle pulse on command completion
rsp_data  out  8  READ result; holds last value otherwise
rsp_nack  out  1  WRITE: slave NACKed (SDA high in ack bit)
rsp_err  out  1  illegal op, or WRITE/READ/STOP while bus not held
bus_held  out  1  START issued and no STOP yet
scl_in  in  1  SCL pad input
scl_t  out  1  1 = release SCL (high-Z), 0 = drive low
scl_out  out  1  constant 0
sda_in  in  1  SDA pad input
sda_t  out  1  1 = release SDA, 0 = drive low
sda_out  out  1  constant 0

Behaviour:
- Reset values: scl_t=1, sda_t=1, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0, bus_held=0. Quarter counter and FSM go to IDLE.
- RST mid-transfer releases both lines on the next cycle. No STOP is generated.
- Handshake:
  - Command is accepted when cmd_valid & cmd_ready. cmd_ready is 1 only in IDLE and drops on the cycle after acceptance.
  - cmd_op, cmd_data and cmd_nack are registered at acceptance.
  - Line outputs change on the cycle after acceptance.
- FSM states: IDLE, START, BIT, ACK, STOP, DONE.
  - Every non-IDLE state except DONE runs four quarters Q0..Q3, each DIV_QUARTER cycles.
- START, 4 quarters:
  - Q0: release SDA.
  - Q1: release SCL.
  - Q2: SDA low.
  - Q3: SCL low.
  - From a free bus, Q0/Q1 cause no line change. While bus_held=1, this produces a repeated START.
  - Sets bus_held=1.
- BIT, one per data bit, 8 per byte, MSB first:
  - Q0: SDA set (WRITE: data bit; READ: released), SCL low.
  - Q1: SCL released.
  - Q2: SCL high; sda_in sampled in the last cycle of Q2.
  - Q3: SCL low.
- ACK: same quarter timing as BIT.
  - WRITE: SDA released; sample gives rsp_nack.
  - READ: SDA driven low if cmd_nack=0, released if cmd_nack=1.
- STOP, 4 quarters:
  - Q0: SDA low.
  - Q1: SCL release.
  - Q2: SDA release.
  - Q3: idle.
  - Clears bus_held.
- Command durations:
  - WRITE/READ: 36 quarters.
  - START/STOP: 4 quarters.
  - Illegal or not-held command: no quarters; no line activity.
- DONE: single cycle.
  - rsp_valid=1; rsp_err/rsp_nack/rsp_data are valid in the same cycle.
  - cmd_ready=1 on the following cycle.
- rsp_nack and rsp_err are updated at every rsp_valid: rsp_nack is 0 for non-WRITE ops; rsp_err is 0 for legal, held commands.
- Between commands with bus_held=1: SCL stays low and SDA holds its last state.
- A new cmd_valid during a busy command is ignored until cmd_ready.

Optional Feature:
I2C_CLOCK_STRETCH_EN.
- Defined: in Q1 of BIT/ACK/START and in STOP Q1, the quarter counter holds at 0 while scl_in=0 after SCL is released. Counting starts on the first cycle scl_in=1, so slaves can stretch the clock.
- Undefined: scl_in is ignored and quarters are fixed length.

Test Plan:
- DIV_QUARTER=4; START, WRITE 0x7C (CPLD addr, W), slave ACKs -> SDA shows 0,1,1,1,1,1,0,0 on SCL rising edges; rsp_nack=0; WRITE lasts 144 cycles; bus_held=1.
- WRITE 0xA5 with slave leaving SDA high in ack bit -> rsp_nack=1, rsp_err=0, SCL low afterward.
- READ, slave drives 0x3C, cmd_nack=1 -> rsp_data=0x3C; SDA released in ACK bit; then STOP -> SDA rises while SCL high; bus_held=0; both t=1.
- WRITE with bus_held=0, and separately cmd_op=3'b111 -> rsp_valid one cycle after acceptance, rsp_err=1, scl_t/sda_t never 0.
- RST asserted at quarter 17 of a WRITE -> next cycle scl_t=1, sda_t=1, cmd_ready=1, bus_held=0, no rsp_valid.
- I2C_CLOCK_STRETCH_EN defined; slave holds scl_in=0 for 20 cycles in bit 3 -> that bit's Q1 extends by 20 cycles; data correct.
